// File: rtl/rr_busarb_pkg.sv
// Shared types and constant helpers for the round-robin bus arbiter.
package rr_busarb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } grant_state_t;

  // Width of an index able to address n items (never narrower than 1 bit).
  function automatic int idx_w(input int n);
    if (n <= 2) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage

// File: rtl/rr_busarb_pick.sv
// Combinational round-robin picker: first request found scanning upward
// from 'start' with wrap-around, returned one-hot together with a valid flag.
module rr_pick
  import rr_busarb_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  grant,
  output logic          valid
);

  logic [IW-1:0] idx;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = IW'((int'(start) + k) % N);
      if (!valid && req[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_busarb.sv
// Round-robin arbiter muxing NMASTER masters onto one shared slave.
// Define RR_BUSARB_HOLD_LIMIT_EN to enable hold-limit preemption with lock.
module rr_busarb
  import rr_busarb_pkg::*;
#(
  parameter int NMASTER = 2,
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int MAXHOLD = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NMASTER-1:0]    breq,
  input  logic [NMASTER-1:0]    lock,
  input  logic [NMASTER*AW-1:0] m_addr,
  input  logic [NMASTER*DW-1:0] m_wdata,
  input  logic [NMASTER-1:0]    m_wen,
  output logic [NMASTER*DW-1:0] m_rdata,
  output logic [NMASTER-1:0]    bgrt,
  output logic [AW-1:0]         s_addr,
  output logic [DW-1:0]         s_wdata,
  output logic                  s_wen,
  input  logic [DW-1:0]         s_rdata
);

  localparam int IW = idx_w(NMASTER);
  localparam logic [IW-1:0] LAST_IDX = IW'(NMASTER - 1);

  grant_state_t        state_reg, state_next;
  logic [NMASTER-1:0]  bgrt_reg, bgrt_next;
  logic [IW-1:0]       last_reg, last_next;
  logic [IW-1:0]       start_idx;
  logic [IW-1:0]       pick_idx;
  logic [NMASTER-1:0]  pick_req;
  logic [NMASTER-1:0]  pick_grant;
  logic                pick_valid;
  logic                own_req;
  logic                preempt;

  // The current owner is masked out so a preemption always moves the grant.
  assign pick_req  = breq & ~bgrt_reg;
  assign start_idx = (last_reg == LAST_IDX) ? '0 : last_reg + 1'b1;
  assign own_req   = |(breq & bgrt_reg);

  rr_pick #(
    .N  (NMASTER),
    .IW (IW)
  ) u_pick (
    .req   (pick_req),
    .start (start_idx),
    .grant (pick_grant),
    .valid (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int k = 0; k < NMASTER; k++) begin
      if (pick_grant[k]) begin
        pick_idx = IW'(k);
      end
    end
  end

`ifdef RR_BUSARB_HOLD_LIMIT_EN
  localparam int CW = idx_w(MAXHOLD);
  localparam logic [CW-1:0] HOLD_TOP = CW'(MAXHOLD - 1);

  logic [CW-1:0] hold_reg, hold_next;
  logic          own_lock;

  assign own_lock = |(lock & bgrt_reg);
  assign preempt  = (state_reg == OWNED) && (hold_reg == HOLD_TOP) &&
                    !own_lock && (|pick_req);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_reg <= '0;
    end else begin
      hold_reg <= hold_next;
    end
  end

  // Restarts on any grant change (including release); otherwise saturates.
  always_comb begin
    hold_next = hold_reg;
    if ((bgrt_next != bgrt_reg) || (state_next == IDLE)) begin
      hold_next = '0;
    end else if (hold_reg != HOLD_TOP) begin
      hold_next = hold_reg + 1'b1;
    end
  end
`else
  logic unused_lock;

  assign unused_lock = ^lock;
  assign preempt     = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      bgrt_reg  <= '0;
      last_reg  <= LAST_IDX;
    end else begin
      state_reg <= state_next;
      bgrt_reg  <= bgrt_next;
      last_reg  <= last_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    bgrt_next  = bgrt_reg;
    last_next  = last_reg;
    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          state_next = OWNED;
          bgrt_next  = pick_grant;
          last_next  = pick_idx;
        end
      end
      OWNED: begin
        if (!own_req || preempt) begin
          if (pick_valid) begin
            bgrt_next = pick_grant;
            last_next = pick_idx;
          end else begin
            state_next = IDLE;
            bgrt_next  = '0;
          end
        end
      end
      default: begin
        state_next = IDLE;
        bgrt_next  = '0;
      end
    endcase
  end

  // Output logic: AND-OR mux on the registered grant, so everything reads
  // zero as soon as the grant register is cleared.
  always_comb begin
    s_addr  = '0;
    s_wdata = '0;
    s_wen   = 1'b0;
    for (int k = 0; k < NMASTER; k++) begin
      if (bgrt_reg[k]) begin
        s_addr  = m_addr[k*AW +: AW];
        s_wdata = m_wdata[k*DW +: DW];
        s_wen   = m_wen[k];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NMASTER; gi++) begin : g_rdata
      assign m_rdata[gi*DW +: DW] = bgrt_reg[gi] ? s_rdata : '0;
    end
  endgenerate

  assign bgrt = bgrt_reg;

  a_onehot_grant : assert property (@(posedge clk) disable iff (rst) $onehot0(bgrt_reg));

endmodule

// File: tb/tb_rr_busarb.sv
// Directed self-checking bench for rr_busarb: a 2-master and a 4-master instance.
// Hold-limit checks follow RR_BUSARB_HOLD_LIMIT_EN when it is defined.
module tb_rr_busarb;

  logic clk;
  logic rst;

  // 2-master instance
  logic [1:0]  a_breq, a_lock, a_wen, a_bgrt;
  logic [15:0] a_addr, a_wdata, a_rdata;
  logic [7:0]  a_saddr, a_swdata, a_srdata;
  logic        a_swen;

  // 4-master instance
  logic [3:0]  b_breq, b_lock, b_wen, b_bgrt;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic [7:0]  b_saddr, b_swdata, b_srdata;
  logic        b_swen;

  int total = 0;
  int bad   = 0;

  rr_busarb #(.NMASTER(2), .AW(8), .DW(8), .MAXHOLD(4)) dut_a (
    .clk(clk), .rst(rst), .breq(a_breq), .lock(a_lock), .m_addr(a_addr),
    .m_wdata(a_wdata), .m_wen(a_wen), .m_rdata(a_rdata), .bgrt(a_bgrt),
    .s_addr(a_saddr), .s_wdata(a_swdata), .s_wen(a_swen), .s_rdata(a_srdata)
  );

  rr_busarb #(.NMASTER(4), .AW(8), .DW(8), .MAXHOLD(4)) dut_b (
    .clk(clk), .rst(rst), .breq(b_breq), .lock(b_lock), .m_addr(b_addr),
    .m_wdata(b_wdata), .m_wen(b_wen), .m_rdata(b_rdata), .bgrt(b_bgrt),
    .s_addr(b_saddr), .s_wdata(b_swdata), .s_wen(b_swen), .s_rdata(b_srdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    a_breq   = '0; a_lock = '0; a_wen = 2'b10;
    a_addr   = {8'hB1, 8'hA0};
    a_wdata  = {8'h22, 8'h11};
    a_srdata = 8'h5C;
    b_breq   = '0; b_lock = '0; b_wen = 4'b0100;
    b_addr   = {8'h33, 8'h22, 8'h11, 8'h00};
    b_wdata  = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
    b_srdata = 8'h77;
    #1;
    chk("rst_bgrt", 32'(a_bgrt), 32'h0);
    chk("rst_swen", 32'(a_swen), 32'h0);
    chk("rst_saddr", 32'(a_saddr), 32'h0);
    tick();
    tick();
    rst = 1'b0;

    // Single request: one-cycle latency, slave mux and read-data return.
    a_breq = 2'b01;
    chk("lat_pre_edge", 32'(a_bgrt), 32'h0);
    tick();
    chk("single_bgrt", 32'(a_bgrt), 32'h1);
    chk("single_saddr", 32'(a_saddr), 32'hA0);
    chk("single_swdata", 32'(a_swdata), 32'h11);
    chk("single_swen", 32'(a_swen), 32'h0);
    chk("single_rdata0", 32'(a_rdata[7:0]), 32'h5C);
    chk("single_rdata1", 32'(a_rdata[15:8]), 32'h0);
    a_breq = 2'b00;
    tick();
    chk("release_bgrt", 32'(a_bgrt), 32'h0);
    chk("release_saddr", 32'(a_saddr), 32'h0);

    // Last owner was 0, so master 1 is searched first now.
    a_breq = 2'b11;
    tick();
    chk("rr_after_m0", 32'(a_bgrt), 32'h2);
    a_breq = 2'b00;
    tick();

    // Both request from reset: 0 first, then 1 with no gap.
    pulse_reset();
    a_breq = 2'b11;
    tick();
    chk("both_first", 32'(a_bgrt), 32'h1);
    tick();
    chk("both_hold", 32'(a_bgrt), 32'h1);
    a_breq = 2'b10;
    tick();
    chk("handover", 32'(a_bgrt), 32'h2);
    chk("handover_saddr", 32'(a_saddr), 32'hB1);
    chk("handover_swen", 32'(a_swen), 32'h1);
    chk("handover_rdata1", 32'(a_rdata[15:8]), 32'h5C);
    chk("handover_rdata0", 32'(a_rdata[7:0]), 32'h0);

    // Asynchronous reset mid-transfer clears grant before the next edge.
    rst = 1'b1;
    #1;
    chk("async_bgrt", 32'(a_bgrt), 32'h0);
    chk("async_swen", 32'(a_swen), 32'h0);
    rst = 1'b0;
    tick();
    chk("post_rst_grant", 32'(a_bgrt), 32'h2);
    a_breq = 2'b00;
    tick();

    // A request withdrawn before being served never gets a grant.
    pulse_reset();
    a_breq = 2'b11;
    tick();
    chk("drop_owner", 32'(a_bgrt), 32'h1);
    a_breq = 2'b01;
    tick();
    chk("drop_still0", 32'(a_bgrt), 32'h1);
    a_breq = 2'b00;
    tick();
    chk("drop_none", 32'(a_bgrt), 32'h0);

`ifdef RR_BUSARB_HOLD_LIMIT_EN
    // Hold limit 4 with contention and no lock: 01 x4, 10 x4, 01 x4.
    pulse_reset();
    a_breq = 2'b11;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("hold_alt%0d", i), 32'(a_bgrt), (((i / 4) % 2) == 0) ? 32'h1 : 32'h2);
    end
    // Lock keeps master 0 past the limit.
    pulse_reset();
    a_lock = 2'b01;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("hold_lock%0d", i), 32'(a_bgrt), 32'h1);
    end
    a_breq = 2'b10;
    tick();
    chk("lock_release", 32'(a_bgrt), 32'h2);
    a_lock = 2'b00;
    // Saturated counter with no competitor: owner keeps the bus.
    pulse_reset();
    a_breq = 2'b01;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("hold_alone%0d", i), 32'(a_bgrt), 32'h1);
    end
`else
    // Without the hold limit the owner keeps the bus under contention.
    pulse_reset();
    a_breq = 2'b11;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("nohold%0d", i), 32'(a_bgrt), 32'h1);
    end
`endif
    a_breq = 2'b00;
    a_lock = 2'b00;

    // Four masters, each owner drops after one cycle: order 0,1,2,3,0.
    pulse_reset();
    b_breq = 4'b1111;
    tick();
    chk("n4_g0", 32'(b_bgrt), 32'h1);
    chk("n4_saddr0", 32'(b_saddr), 32'h00);
    b_breq = 4'b1110;
    tick();
    chk("n4_g1", 32'(b_bgrt), 32'h2);
    chk("n4_swdata1", 32'(b_swdata), 32'hD1);
    b_breq = 4'b1100;
    tick();
    chk("n4_g2", 32'(b_bgrt), 32'h4);
    chk("n4_saddr2", 32'(b_saddr), 32'h22);
    chk("n4_swen2", 32'(b_swen), 32'h1);
    chk("n4_rdata2", 32'(b_rdata), 32'h0077_0000);
    b_breq = 4'b1000;
    tick();
    chk("n4_g3", 32'(b_bgrt), 32'h8);
    chk("n4_swen3", 32'(b_swen), 32'h0);
    b_breq = 4'b0111;
    tick();
    chk("n4_g0_again", 32'(b_bgrt), 32'h1);
    b_breq = 4'b0000;
    tick();
    chk("n4_idle", 32'(b_bgrt), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
